// File: rtl/pixel_framebuffer_scanout.sv
// ============================================================================
// Module  : pixel_framebuffer_scanout
// Purpose : 3-bit colour framebuffer written by pixel strobes and scanned out
//           as 640x480@60 VGA with 4x4 pixel replication.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pixel_framebuffer_scanout #(
  parameter int FB_W   = 160,
  parameter int FB_H   = 120,
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       plot,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       frame_start
);

  localparam int MEM_DEPTH = FB_W * FB_H;
  localparam int AW        = $clog2(MEM_DEPTH);

  localparam logic [7:0] c_fb_w     = 8'(FB_W);
  localparam logic [6:0] c_fb_h     = 7'(FB_H);
  localparam logic [9:0] c_h_vis    = 10'(H_VIS);
  localparam logic [9:0] c_h_last   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] c_hs_beg   = 10'(H_VIS + H_FP);
  localparam logic [9:0] c_hs_end   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] c_v_vis    = 10'(V_VIS);
  localparam logic [9:0] c_v_last   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] c_vs_beg   = 10'(V_VIS + V_FP);
  localparam logic [9:0] c_vs_end   = 10'(V_VIS + V_FP + V_SYNC);

  logic [2:0]    r_mem [MEM_DEPTH];
  logic [2:0]    r_rdata;
  logic          r_pe;
  logic [9:0]    r_hcount;
  logic [9:0]    r_vcount;
  logic          r_s1_hs;
  logic          r_s1_vs;
  logic          r_s1_vis;
  logic [2:0]    r_s1_pix;

  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic          w_vis;
  logic [AW-1:0] w_raddr;
  logic          w_hs_n;
  logic          w_vs_n;

  // Out-of-range coordinates must be rejected before the address truncates.
  assign w_we    = plot && (x < c_fb_w) && (y < c_fb_h);
  assign w_waddr = AW'(y) * AW'(FB_W) + AW'(x);

  assign w_vis   = (r_hcount < c_h_vis) && (r_vcount < c_v_vis);
  assign w_raddr = w_vis ? (AW'(r_vcount[9:2]) * AW'(FB_W) + AW'(r_hcount[9:2])) : '0;

  assign w_hs_n  = !((r_hcount >= c_hs_beg) && (r_hcount < c_hs_end));
  assign w_vs_n  = !((r_vcount >= c_vs_beg) && (r_vcount < c_vs_end));

  // Read-first dual-port RAM; contents deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= colour;
    end
    r_rdata <= r_mem[w_raddr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pe        <= 1'b0;
      r_hcount    <= '0;
      r_vcount    <= '0;
      r_s1_hs     <= 1'b1;
      r_s1_vs     <= 1'b1;
      r_s1_vis    <= 1'b0;
      r_s1_pix    <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      frame_start <= 1'b0;
    end else begin
      r_pe        <= ~r_pe;
      frame_start <= r_pe && (r_hcount == '0) && (r_vcount == '0);
      if (r_pe) begin
        if (r_hcount == c_h_last) begin
          r_hcount <= '0;
          r_vcount <= (r_vcount == c_v_last) ? '0 : r_vcount + 10'd1;
        end else begin
          r_hcount <= r_hcount + 10'd1;
        end
        // r_rdata was fetched in the preceding pe=0 cycle for this count.
        r_s1_hs     <= w_hs_n;
        r_s1_vs     <= w_vs_n;
        r_s1_vis    <= w_vis;
        r_s1_pix    <= r_rdata;
        vga_hs      <= r_s1_hs;
        vga_vs      <= r_s1_vs;
        vga_blank_n <= r_s1_vis;
        vga_r       <= (r_s1_vis && r_s1_pix[2]) ? 8'hFF : 8'h00;
        vga_g       <= (r_s1_vis && r_s1_pix[1]) ? 8'hFF : 8'h00;
        vga_b       <= (r_s1_vis && r_s1_pix[0]) ? 8'hFF : 8'h00;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pixel_framebuffer_scanout.sv
// ============================================================================
// Module  : tb_pixel_framebuffer_scanout
// Purpose : Scanout bench on a reduced raster, compared against a
//           time-indexed model of the VGA outputs.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pixel_framebuffer_scanout;

  localparam int FB_W   = 16;
  localparam int FB_H   = 8;
  localparam int H_VIS  = 64;
  localparam int H_FP   = 4;
  localparam int H_SYNC = 8;
  localparam int H_BP   = 4;
  localparam int V_VIS  = 32;
  localparam int V_FP   = 3;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 3;
  localparam int HT     = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT     = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int F      = HT * VT;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_blank_n;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;
  logic       frame_start;

  always #5 clk = ~clk;

  pixel_framebuffer_scanout #(
    .FB_W(FB_W), .FB_H(FB_H),
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_dut (
    .clk(clk), .reset(reset),
    .x(x), .y(y), .colour(colour), .plot(plot),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          fb [FB_W*FB_H];
  logic [17:0] wq [$];
  int          collide_n   = -1;
  int          collide_old = 0;

  task automatic chk(input string tag, input logic [27:0] got, input logic [27:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [27:0] obs();
    return {vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b, frame_start};
  endfunction

  // Pins show pixel-period n from 4 clk after release onward; frame_start
  // fires 2 clk after release and every 2*F clk thereafter.
  function automatic logic [27:0] model(input int t);
    int   n, p, h, v, col;
    logic hs, vs, vis, fs;
    fs = (t >= 2) && (((t - 2) % (2 * F)) == 0);
    if (t < 4) return {2'b11, 25'd0, fs};
    n   = (t - 4) / 2;
    p   = n % F;
    h   = p % HT;
    v   = p / HT;
    vis = (h < H_VIS) && (v < V_VIS);
    hs  = !((h >= H_VIS + H_FP) && (h < H_VIS + H_FP + H_SYNC));
    vs  = !((v >= V_VIS + V_FP) && (v < V_VIS + V_FP + V_SYNC));
    col = 0;
    if (vis) col = (n == collide_n) ? collide_old : fb[(v / 4) * FB_W + h / 4];
    return {hs, vs, vis, {8{col[2]}}, {8{col[1]}}, {8{col[0]}}, fs};
  endfunction

  task automatic issue(input logic [17:0] e);
    x      = e[17:10];
    y      = e[9:3];
    colour = e[2:0];
    plot   = 1'b1;
    if (int'(x) < FB_W && int'(y) < FB_H) fb[int'(y) * FB_W + int'(x)] = int'(colour);
  endtask

  task automatic queue_frame(input int f);
    int xr, yr, cr;
    case (f)
      0: begin
        wq.push_back({8'(FB_W), 7'd0, 3'd7});
        wq.push_back({8'd0, 7'(FB_H), 3'd7});
        wq.push_back({8'd160, 7'd0, 3'd7});
        wq.push_back({8'd255, 7'd127, 3'd7});
        wq.push_back({8'd5, 7'd3, 3'b101});
      end
      1: for (int i = 0; i < FB_W; i++) wq.push_back({8'(i), 7'(FB_H - 1), 3'((i % 7) + 1)});
      2: for (int i = 0; i < 24; i++) begin
        xr = int'($urandom_range(FB_W + 3, 1));
        yr = int'($urandom_range(FB_H + 1, 0));
        cr = int'($urandom_range(7, 1));
        wq.push_back({8'(xr), 7'(yr), 3'(cr)});
      end
      default: ;
    endcase
  endtask

  initial begin
    int t, n, v, last_f;
    reset  = 1'b1;
    plot   = 1'b0;
    x      = '0;
    y      = '0;
    colour = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < FB_W * FB_H; i++) begin
      x      = 8'(i % FB_W);
      y      = 7'(i / FB_W);
      colour = 3'd0;
      plot   = 1'b1;
      @(negedge clk);
    end
    plot = 1'b0;
    repeat (1000) @(negedge clk);

    // Mid-frame reset held for 4 clk.
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("reset_idle", obs(), {2'b11, 26'd0});
    end
    reset = 1'b0;

    t      = 0;
    last_f = -1;
    while (t < 10 * F + 8) begin
      n    = t / 2;
      v    = (n % F) / HT;
      plot = 1'b0;
      if (n / F != last_f) begin
        last_f = n / F;
        queue_frame(last_f);
      end
      if (t == 6 * F) begin
        collide_n   = n;
        collide_old = fb[0];
        issue({8'd0, 7'd0, 3'b010});
      end else if (wq.size() > 0 && v >= V_VIS + 1 && v <= VT - 2) begin
        issue(wq.pop_front());
      end
      @(negedge clk);
      t++;
      chk($sformatf("scan t=%0d", t), obs(), model(t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
